// File: rtl/barrier_sequencer.sv
// Round sequencer for the barrier sprites: launches one barrier per round, books dodges/collisions.
// Optional build macro BARRIER_SEQ_ESCALATE_EN shortens the inter-round gap as the score grows.
module barrier_sequencer #(
  parameter int unsigned GAP_FRAMES     = 30,
  parameter int unsigned HIT_FRAMES     = 4,
  parameter int unsigned TIMEOUT_FRAMES = 64,
  parameter logic [1:0]  START_LIVES    = 2'd3,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_v_sync,
  input  logic        i_start,
  input  logic [2:0]  i_in_position,
  input  logic [2:0]  i_overlap,
  output logic [2:0]  o_active,
  output logic [15:0] o_score,
  output logic [1:0]  o_lives,
  output logic        o_collision,
  output logic        o_game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_LAUNCH,
    S_APPROACH,
    S_HIT,
    S_RETIRE,
    S_GAME_OVER
  } state_t;

  state_t      state, state_nxt;
  logic        vsync_p0, vsync_p1, vsync_p2;
  logic        frame_tick;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [15:0] frame_cnt, frame_cnt_nxt, cnt_inc;
  logic [15:0] gap_len;
  logic        coll_flag, coll_flag_nxt;
  logic [2:0]  active_nxt;
  logic [15:0] score_nxt;
  logic [1:0]  lives_nxt;
  logic        coll_nxt;
  logic        lane_pos, lane_ovl;

  function automatic logic [1:0] lane_from_lfsr(input logic [1:0] r);
    return (r == 2'd3) ? 2'd1 : r;
  endfunction

  function automatic logic [2:0] lane_onehot(input logic [1:0] l);
    return 3'b001 << l;
  endfunction

  function automatic logic [15:0] score_sat_inc(input logic [15:0] s);
    return (s == 16'hFFFF) ? s : s + 16'd1;
  endfunction

  function automatic logic [1:0] lives_dec(input logic [1:0] l);
    return (l == 2'd0) ? 2'd0 : l - 2'd1;
  endfunction

`ifdef BARRIER_SEQ_ESCALATE_EN
  // Two frames shaved off per eight dodges, never below an 8-frame gap.
  function automatic logic [15:0] gap_for_score(input logic [15:0] s);
    logic [16:0] dec;
    logic [16:0] base;
    dec  = {3'b000, s[15:3], 1'b0};
    base = 17'(GAP_FRAMES);
    if (base < dec + 17'd8) return 16'd8;
    return 16'(base - dec);
  endfunction

  assign gap_len = gap_for_score(o_score);
`else
  assign gap_len = 16'(GAP_FRAMES);
`endif

  // v_sync synchronizer stages and edge detect
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vsync_p0 <= 1'b0;
      vsync_p1 <= 1'b0;
      vsync_p2 <= 1'b0;
    end else begin
      vsync_p0 <= i_v_sync;
      vsync_p1 <= vsync_p0;
      vsync_p2 <= vsync_p1;
    end
  end

  assign frame_tick = vsync_p1 & ~vsync_p2;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge i_clk) begin
    if (i_rst) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // o_active holds the latched lane one-hot for the whole round
  assign lane_pos = |(i_in_position & o_active);
  assign lane_ovl = |(i_overlap & o_active);
  assign cnt_inc  = frame_cnt + 16'd1;

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    coll_flag_nxt = coll_flag;
    active_nxt    = o_active;
    score_nxt     = o_score;
    lives_nxt     = o_lives;
    coll_nxt      = 1'b0;
    case (state)
      S_IDLE, S_GAME_OVER: begin
        active_nxt = 3'b000;
        if (i_start) begin
          score_nxt     = 16'd0;
          lives_nxt     = START_LIVES;
          frame_cnt_nxt = 16'd0;
          state_nxt     = S_GAP;
        end
      end
      S_GAP: begin
        if (frame_tick) begin
          if (cnt_inc >= gap_len) begin
            frame_cnt_nxt = 16'd0;
            state_nxt     = S_LAUNCH;
          end else begin
            frame_cnt_nxt = cnt_inc;
          end
        end
      end
      S_LAUNCH: begin
        active_nxt    = lane_onehot(lane_from_lfsr(lfsr[1:0]));
        frame_cnt_nxt = 16'd0;
        coll_flag_nxt = 1'b0;
        state_nxt     = S_APPROACH;
      end
      S_APPROACH: begin
        // Arrival takes priority over a timeout tick in the same cycle.
        if (lane_pos) begin
          frame_cnt_nxt = 16'd0;
          state_nxt     = S_HIT;
        end else if (frame_tick) begin
          if (cnt_inc >= 16'(TIMEOUT_FRAMES)) begin
            frame_cnt_nxt = 16'd0;
            active_nxt    = 3'b000;
            state_nxt     = S_RETIRE;
          end else begin
            frame_cnt_nxt = cnt_inc;
          end
        end
      end
      S_HIT: begin
        if (lane_ovl) coll_flag_nxt = 1'b1;
        if (frame_tick) begin
          if (cnt_inc >= 16'(HIT_FRAMES)) begin
            frame_cnt_nxt = 16'd0;
            active_nxt    = 3'b000;
            state_nxt     = S_RETIRE;
            if (coll_flag | lane_ovl) begin
              lives_nxt = lives_dec(o_lives);
              coll_nxt  = 1'b1;
            end else begin
              score_nxt = score_sat_inc(o_score);
            end
          end else begin
            frame_cnt_nxt = cnt_inc;
          end
        end
      end
      S_RETIRE: begin
        // Two inactive frames so the barrier sees an inactive v_sync edge.
        active_nxt = 3'b000;
        if (frame_tick) begin
          if (cnt_inc >= 16'd2) begin
            frame_cnt_nxt = 16'd0;
            state_nxt     = (o_lives == 2'd0) ? S_GAME_OVER : S_GAP;
          end else begin
            frame_cnt_nxt = cnt_inc;
          end
        end
      end
      default: begin
        active_nxt = 3'b000;
        state_nxt  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      frame_cnt   <= 16'd0;
      coll_flag   <= 1'b0;
      o_active    <= 3'b000;
      o_score     <= 16'd0;
      o_lives     <= 2'd0;
      o_collision <= 1'b0;
      o_game_over <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_cnt   <= frame_cnt_nxt;
      coll_flag   <= coll_flag_nxt;
      o_active    <= active_nxt;
      o_score     <= score_nxt;
      o_lives     <= lives_nxt;
      o_collision <= coll_nxt;
      o_game_over <= (state_nxt == S_GAME_OVER);
    end
  end

endmodule

// File: doc/barrier_sequencer.md
# barrier_sequencer

Game-flow controller that drives the barrier sprites from the other end of their `active`/`in_position` handshake. It launches one barrier per round into one of three lanes (left/mid/right), waits for that barrier to report it is in position, and samples player overlap during a short hit window. It then retires the barrier and updates score and lives. It sits between the barrier sprite instances and the score/HUD logic, clocked by the pixel clock, with frame timing derived from `i_v_sync`.

## Interface
Parameters:
- `GAP_FRAMES`, 30: idle frames between a retire and the next launch.
- `HIT_FRAMES`, 4: frames after `in_position` during which overlap counts as a collision.
- `TIMEOUT_FRAMES`, 64: maximum approach frames before the barrier is aborted.
- `START_LIVES`, 3: lives loaded on start; range 1..3.
- `LFSR_SEED`, 16'hACE1: lane-select LFSR reset value; must be nonzero.

Ports:
- `i_clk`  in  1  pixel clock; only clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_v_sync`  in  1  vertical sync; asynchronous to nothing, but treated as a level input.
- `i_start`  in  1  start/restart request; sampled in IDLE and GAME_OVER.
- `i_in_position`  in  3  per-lane barrier `in_position`; bit0 = left, bit1 = mid, bit2 = right.
- `i_overlap`  in  3  per-lane pixel overlap, defined as barrier `o_sprite_hit` AND player sprite hit.
- `o_active`  out  3  per-lane barrier `active`; one-hot or zero.
- `o_score`  out  16  barriers dodged.
- `o_lives`  out  2  remaining lives.
- `o_collision`  out  1  one-`i_clk` pulse when a collision is booked.
- `o_game_over`  out  1  high while in GAME_OVER.

## Operation
- **Frame tick:** `i_v_sync` passes through a 2-flop synchronizer. The rising edge of the synchronized signal produces `frame_tick`, a one-cycle pulse. All frame counters advance only on `frame_tick`.
- **LFSR:** 16-bit Fibonacci LFSR, taps 16,14,13,11, stepped every `i_clk`.
  - Lane select = `lfsr[1:0]`; value 3 maps to lane 1 (mid).
- **IDLE:**
  - `o_active` = 0.
  - On `i_start`: load `o_score` = 0 and `o_lives` = `START_LIVES`, then go to GAP.
- **GAP:**
  - Count `frame_tick`s.
  - At count == `GAP_FRAMES` → LAUNCH.
- **LAUNCH** (1 cycle):
  - Latch the lane.
  - Set `o_active` to the one-hot lane.
  - Clear the frame counter and collision flag → APPROACH.
- **APPROACH:**
  - On `i_in_position[lane]` high → HIT.
  - Else, when counter reaches `TIMEOUT_FRAMES` → RETIRE with no score and no life change (abort).
- **HIT:**
  - Any cycle with `i_overlap[lane]` sets the collision flag (sticky).
  - Overlap on non-selected lanes is ignored.
  - After `HIT_FRAMES` frame_ticks → RETIRE.
  - Round outcome:
    - Collision flag set: `o_lives` decrements and `o_collision` pulses on the RETIRE entry cycle.
    - Flag clear: `o_score` increments, saturating at 16'hFFFF.
- **RETIRE:**
  - `o_active` = 0 for exactly 2 frame_ticks, which guarantees the barrier sees an inactive v_sync edge and resets.
  - Then → GAME_OVER if `o_lives` == 0, else → GAP.
- **GAME_OVER:**
  - `o_active` = 0 and `o_game_over` = 1.
  - `o_score` and `o_lives` hold.
  - `i_start` → reload as in IDLE → GAP.
- **Decrement rule:** `o_lives` never wraps; a decrement at 0 is impossible by construction.

## Timing
- **Reset values:** state = IDLE; `o_active` = 0, `o_score` = 0, `o_lives` = 0, `o_collision` = 0, `o_game_over` = 0; LFSR = `LFSR_SEED`; counters = 0.
- **Reset mid-round:** `o_active` drops on the next clock edge.
- **frame_tick latency:** 2–3 `i_clk` cycles after the `i_v_sync` rising edge.
- **Output registration:** all outputs are registered.
  - `o_active` changes on the clock after the LAUNCH/RETIRE transition.
- **Same-cycle events:** `frame_tick` and `i_overlap` in the same cycle on the last HIT frame: overlap counts.
- **Position and timeout together:** `i_in_position` and the timeout in the same cycle: `in_position` wins.
- **Start in other states:** `i_start` outside IDLE/GAME_OVER is ignored.

## Configuration
- **`BARRIER_SEQ_ESCALATE_EN` defined:**
  - Effective gap = `GAP_FRAMES` − 2 × (`o_score` / 8), floored at 8 frames.
  - Reset to `GAP_FRAMES` on start.
- **`BARRIER_SEQ_ESCALATE_EN` undefined:** gap is fixed at `GAP_FRAMES`.

## Test plan
- **Reset and start:** reset, then `i_start`, then 30 v_sync pulses → `o_active` one-hot; `o_lives` = 3; `o_score` = 0.
- **Clean dodge:** assert `i_in_position[lane]` after 29 frames, no overlap for 4 frames → `o_score` = 1; `o_active` = 0 for 2 frames, then a new launch after the 30-frame gap.
- **Collision:** one-cycle `i_overlap[lane]` in HIT frame 3 → `o_collision` single pulse; `o_lives` 3→2; score unchanged. Overlap on a non-selected lane → no effect.
- **Timeout:** hold `i_in_position` = 0 for 64 frames → RETIRE; score and lives unchanged.
- **Game over:** three collisions → `o_game_over` = 1, `o_lives` = 0, `o_active` = 0. Then `i_start` → `o_lives` = 3, `o_score` = 0.
- **Escalation and mid-round reset:** with `BARRIER_SEQ_ESCALATE_EN`, score 16 → gap 26 frames. Reset during APPROACH → `o_active` = 0 on the next cycle and state IDLE.
